counter_move_scheduler: RTL and testbench

Sequences the 0..MAXV up/down counter so it moves to requested target values without user button presses. Two requesters (A, B) share the counter through a round-robin arbiter. The block drives the counter's up/down inputs one step per clk1hz cycle along the shortest wrap-around path. It keeps a mirrored position register that tracks the counter value exactly, because both blocks use the same clock and reset.

---
 rtl/counter_move_scheduler.sv | 134 +++++++++++++
 tb/tb_counter_move_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_move_scheduler.sv
// Drives the wrap-around up/down counter to requested targets along the shortest path,
// arbitrating two requesters round-robin and forwarding manual steps when idle.
module counter_move_scheduler #(
    parameter int MAXV = 8,
    parameter int W    = 4
) (
    input  logic         clk1hz,
    input  logic         reset,
    input  logic         req_a,
    input  logic         req_b,
    input  logic [W-1:0] tgt_a,
    input  logic [W-1:0] tgt_b,
    input  logic         manual_up,
    input  logic         manual_down,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         done_a,
    output logic         done_b,
    output logic         err,
    output logic         up,
    output logic         down,
    output logic [W-1:0] pos,
    output logic         busy
);
    // state | meaning
    // IDLE  | arbitrate requests, forward manual steps
    // MOVE  | issue one step per cycle until rem = 0, then pulse done

    localparam logic [W-1:0] MAXV_P = W'(MAXV);
    localparam logic [W:0]   MAXV_X = (W+1)'(MAXV);
    localparam logic [W:0]   N_X    = (W+1)'(MAXV + 1);

    typedef enum logic {IDLE, MOVE} state_t;

    state_t       state;
    logic [W-1:0] rem;
    logic         dir_up;
    logic         last_b;
    logic         owner_b;

    logic [W-1:0] pos_inc, pos_dec, pos_eff, tgt_sel;
    logic         pick_a, pick_b, tgt_ok;
    logic [W:0]   t_x, p_x, du_raw, dd_raw, d_up, d_dn;

    // The move is planned from the position the counter will hold after this edge,
    // so a step still in flight (e.g. a manual step) is accounted for.
    always_comb begin
        pos_inc = (pos == MAXV_P) ? '0 : pos + W'(1);
        pos_dec = (pos == '0) ? MAXV_P : pos - W'(1);
        pos_eff = up ? pos_inc : (down ? pos_dec : pos);
        pick_a  = req_a && (!req_b || last_b);
        pick_b  = req_b && !pick_a;
        tgt_sel = pick_b ? tgt_b : tgt_a;
        t_x     = {1'b0, tgt_sel};
        p_x     = {1'b0, pos_eff};
        tgt_ok  = (t_x <= MAXV_X);
        du_raw  = t_x + N_X - p_x;
        dd_raw  = p_x + N_X - t_x;
        d_up    = (du_raw >= N_X) ? du_raw - N_X : du_raw;
        d_dn    = (dd_raw >= N_X) ? dd_raw - N_X : dd_raw;
    end

    assign busy = (state == MOVE);

    always_ff @(posedge clk1hz) begin
        if (reset) begin
            state   <= IDLE;
            pos     <= '0;
            rem     <= '0;
            dir_up  <= 1'b1;
            last_b  <= 1'b1;
            owner_b <= 1'b0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            done_a  <= 1'b0;
            done_b  <= 1'b0;
            err     <= 1'b0;
            up      <= 1'b0;
            down    <= 1'b0;
        end else begin
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            err    <= 1'b0;
            up     <= 1'b0;
            down   <= 1'b0;

            // The counter takes its step on this same edge, keeping pos in lockstep.
            if (up)
                pos <= pos_inc;
            else if (down)
                pos <= pos_dec;

            case (state)
                IDLE: begin
                    if (pick_a || pick_b) begin
                        gnt_a   <= pick_a;
                        gnt_b   <= pick_b;
                        last_b  <= pick_b;
                        owner_b <= pick_b;
                        if (tgt_ok) begin
                            state <= MOVE;
                            if (d_up <= d_dn) begin
                                dir_up <= 1'b1;
                                rem    <= d_up[W-1:0];
                            end else begin
                                dir_up <= 1'b0;
                                rem    <= d_dn[W-1:0];
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (manual_up ^ manual_down) begin
                        up   <= manual_up;
                        down <= manual_down;
                    end
                end
                MOVE: begin
                    if (rem != '0) begin
                        up   <= dir_up;
                        down <= !dir_up;
                        rem  <= rem - W'(1);
                    end else begin
                        done_a <= !owner_b;
                        done_b <= owner_b;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_move_scheduler.sv
// Scoreboard bench: per-cycle expected outputs are queued with their due cycle when
// stimulus is driven, then popped and compared on the falling edge.
module tb_counter_move_scheduler;
    logic       clk1hz = 1'b0;
    logic       reset = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [3:0] tgt_a = '0, tgt_b = '0;
    logic       manual_up = 1'b0, manual_down = 1'b0;
    logic       gnt_a, gnt_b, done_a, done_b, err, up, down, busy;
    logic [3:0] pos;

    counter_move_scheduler #(.MAXV(8), .W(4)) dut (
        .clk1hz(clk1hz), .reset(reset),
        .req_a(req_a), .req_b(req_b), .tgt_a(tgt_a), .tgt_b(tgt_b),
        .manual_up(manual_up), .manual_down(manual_down),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .err(err), .up(up), .down(down), .pos(pos), .busy(busy)
    );

    always #5 clk1hz = ~clk1hz;

    int cyc = 0;
    always @(posedge clk1hz) cyc++;

    typedef struct {
        int          cyc;
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_pass = 0;
    int m_pos = 0;

    logic [31:0] obs;
    assign obs = {20'd0, gnt_a, gnt_b, done_a, done_b, err, up, down, busy, pos};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    endtask

    // field order: gnt_a gnt_b done_a done_b err up down busy pos
    function automatic logic [31:0] pk(input bit ga, input bit gb, input bit da, input bit db,
                                       input bit e, input bit u, input bit dn, input bit b,
                                       input int p);
        logic [31:0] pv;
        pv = p;
        return {20'd0, ga, gb, da, db, e, u, dn, b, pv[3:0]};
    endfunction

    function automatic int stepf(input int p, input bit u);
        if (u) return (p == 8) ? 0 : p + 1;
        return (p == 0) ? 8 : p - 1;
    endfunction

    task automatic push(input int c, input string tag, input logic [31:0] v);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    // Expected timeline of one accepted request whose gnt is visible in cycle c0.
    task automatic push_move(input int who, input int p, input int t, input int c0, input string tag);
        bit a;
        int du, dd, d, q;
        bit u;
        a = (who == 0);
        if (t > 8) begin
            push(c0, {tag, "_gnt_err"}, pk(a, !a, 0, 0, 1, 0, 0, 0, p));
        end else begin
            du = (t - p + 9) % 9;
            dd = (p - t + 9) % 9;
            u  = (du <= dd);
            d  = u ? du : dd;
            q  = p;
            push(c0, {tag, "_gnt"}, pk(a, !a, 0, 0, 0, 0, 0, 1, p));
            for (int k = 1; k <= d; k++) begin
                push(c0 + k, $sformatf("%s_step%0d", tag, k), pk(0, 0, 0, 0, 0, u, !u, 1, q));
                q = stepf(q, u);
            end
            push(c0 + d + 1, {tag, "_done"}, pk(0, 0, a, !a, 0, 0, 0, 0, t));
        end
    endtask

    exp_t cur;
    always @(negedge clk1hz) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.cyc < cyc) chk_eq({cur.tag, "_missed"}, cyc, cur.cyc);
            else chk_eq(cur.tag, obs, cur.v);
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk1hz);
        if (sb.size() != 0) begin
            chk_eq("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk1hz);
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0; manual_up = 1'b0; manual_down = 1'b0;
        push(cyc + 1, tag, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk1hz);
        reset = 1'b0;
        m_pos = 0;
        wait_drain();
    endtask

    task automatic run_move(input int who, input int t, input string tag);
        if (who == 0) begin req_a = 1'b1; tgt_a = 4'(t); end
        else          begin req_b = 1'b1; tgt_b = 4'(t); end
        push_move(who, m_pos, t, cyc + 1, tag);
        @(negedge clk1hz);
        req_a = 1'b0; req_b = 1'b0;
        if (t <= 8) m_pos = t;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        do_reset("reset");

        run_move(0, 3, "a3");
        run_move(0, 1, "a1_down");
        run_move(1, 7, "b7_wrap");

        // Simultaneous requests: A wins the first tie, B is granted once A is done.
        do_reset("reset_pair");
        req_a = 1'b1; tgt_a = 4'd2; req_b = 1'b1; tgt_b = 4'd5;
        c0 = cyc + 1;
        push_move(0, 0, 2, c0, "pair_a");
        push_move(1, 2, 5, c0 + 4, "pair_b");
        @(negedge clk1hz);
        req_a = 1'b0;
        repeat (4) @(negedge clk1hz);
        req_b = 1'b0;
        m_pos = 5;
        wait_drain();

        run_move(0, 9, "inv");
        push(cyc + 1, "inv_quiet", pk(0, 0, 0, 0, 0, 0, 0, 0, m_pos));
        wait_drain();

        // Reset lands after two of four steps: everything clears, no done.
        do_reset("reset_mid");
        req_a = 1'b1; tgt_a = 4'd4;
        c0 = cyc + 1;
        push(c0,     "mid_gnt",   pk(1, 0, 0, 0, 0, 0, 0, 1, 0));
        push(c0 + 1, "mid_step1", pk(0, 0, 0, 0, 0, 1, 0, 1, 0));
        push(c0 + 2, "mid_step2", pk(0, 0, 0, 0, 0, 1, 0, 1, 1));
        @(negedge clk1hz);
        req_a = 1'b0;
        repeat (2) @(negedge clk1hz);
        reset = 1'b1;
        push(c0 + 3, "mid_clear",  pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(c0 + 4, "mid_nodone", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk1hz);
        reset = 1'b0;
        m_pos = 0;
        wait_drain();

        run_move(0, 8, "to8");
        manual_up = 1'b1;
        push(cyc + 1, "man_up",   pk(0, 0, 0, 0, 0, 1, 0, 0, 8));
        push(cyc + 2, "man_wrap", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk1hz);
        manual_up = 1'b0;
        m_pos = 0;
        wait_drain();

        manual_up = 1'b1; manual_down = 1'b1;
        push(cyc + 1, "man_both1", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(cyc + 2, "man_both2", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk1hz);
        manual_up = 1'b0; manual_down = 1'b0;
        wait_drain();

        manual_up = 1'b1; req_a = 1'b1; tgt_a = 4'd2;
        push_move(0, 0, 2, cyc + 1, "man_req");
        @(negedge clk1hz);
        manual_up = 1'b0; req_a = 1'b0;
        m_pos = 2;
        wait_drain();
        push(cyc + 1, "man_req_quiet", pk(0, 0, 0, 0, 0, 0, 0, 0, 2));
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
